// File: rtl/nl_ops_pkg.sv
// Shared definitions for the non-linear ops datapath: FSM state encoding for
// vec_accum and signed range helpers used by saturating arithmetic.
package nl_ops_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      OUT  = 2'd2
   } vec_accum_state_t;

   localparam int MAX_W = 128;

   // Largest signed value representable in w bits, right-aligned in MAX_W bits.
   function automatic logic [MAX_W-1:0] SMAX(input int w);
      return (MAX_W'(1) << (w - 1)) - MAX_W'(1);
   endfunction

   // Most negative signed value in w bits; the caller truncates to w bits.
   function automatic logic [MAX_W-1:0] SMIN(input int w);
      return MAX_W'(1) << (w - 1);
   endfunction

endpackage

// File: rtl/add.sv
// Plain two's-complement adder/subtractor used across the datapath.
// addsub = 0 gives add_i1 + add_i2, addsub = 1 gives add_i1 - add_i2; the
// result wraps modulo 2^WIDTH and carries no overflow indication.
module add #(
   parameter int WIDTH = 64
) (
   input  logic [WIDTH-1:0] add_i1,
   input  logic [WIDTH-1:0] add_i2,
   input  logic             addsub,
   output logic [WIDTH-1:0] add_o
);

   // Select sum or difference of the two operands.
   always_comb begin
      add_o = addsub ? (add_i1 - add_i2) : (add_i1 + add_i2);
   end

endmodule

// File: rtl/vec_accum.sv
// vec_accum: streaming signed sum/difference of a run of len elements,
// delivered as one result over a valid/ready handshake.
// Optional feature: define VEC_ACCUM_SAT_EN to clamp the accumulator to the
// signed range on overflow instead of wrapping. ovf reports overflow either way.
module vec_accum
   import nl_ops_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int LEN_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic             addsub,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             ovf,
   output logic             busy
);

`ifdef VEC_ACCUM_SAT_EN
   localparam logic [WIDTH-1:0] SMAX_V = WIDTH'(SMAX(WIDTH));
   localparam logic [WIDTH-1:0] SMIN_V = WIDTH'(SMIN(WIDTH));
`endif

   vec_accum_state_t state;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] acc_next;
   logic [LEN_W-1:0] cnt;
   logic             mode;
   logic             ovf_q;
   logic             out_valid_q;
   logic             beat_ovf;

   add #(.WIDTH(WIDTH)) u_add (
      .add_i1 (acc),
      .add_i2 (in_data),
      .addsub (mode),
      .add_o  (sum)
   );

   // Detect signed overflow of this beat and choose the next accumulator
   // value; the sign of acc tells whether the true result ran high or low.
   always_comb begin
      if (mode) begin
         beat_ovf = (acc[WIDTH-1] != in_data[WIDTH-1]) && (sum[WIDTH-1] != acc[WIDTH-1]);
      end else begin
         beat_ovf = (acc[WIDTH-1] == in_data[WIDTH-1]) && (sum[WIDTH-1] != acc[WIDTH-1]);
      end
      acc_next = sum;
`ifdef VEC_ACCUM_SAT_EN
      if (beat_ovf) begin
         acc_next = acc[WIDTH-1] ? SMIN_V : SMAX_V;
      end
`endif
   end

   // Run control: latch the run on start, fold accepted beats into acc,
   // then hold the result until the consumer takes it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         acc         <= '0;
         cnt         <= '0;
         mode        <= 1'b0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  acc   <= '0;
                  ovf_q <= 1'b0;
                  mode  <= addsub;
                  if (len == '0) begin
                     cnt         <= '0;
                     state       <= OUT;
                     out_valid_q <= 1'b1;
                  end else begin
                     cnt   <= len;
                     state <= ACC;
                  end
               end
            end
            ACC: begin
               if (in_valid) begin
                  acc   <= acc_next;
                  ovf_q <= ovf_q | beat_ovf;
                  cnt   <= cnt - LEN_W'(1);
                  if (cnt == LEN_W'(1)) begin
                     state       <= OUT;
                     out_valid_q <= 1'b1;
                  end
               end
            end
            OUT: begin
               if (out_ready) begin
                  state       <= IDLE;
                  out_valid_q <= 1'b0;
               end
            end
            default: begin
               state       <= IDLE;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   // Handshake and status decode straight from the state register.
   always_comb begin
      in_ready = (state == ACC);
      busy     = (state != IDLE);
   end

   assign out_valid = out_valid_q;
   assign out_data  = acc;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_vec_accum.sv
// Self-checking bench for vec_accum: a 64-bit instance for run control,
// handshakes and random sums, and an 8-bit instance for overflow behaviour.
// Expected results come from exact wide arithmetic clipped to the element
// width (wrap or clamp depending on VEC_ACCUM_SAT_EN).
module tb_vec_accum;

   localparam int W  = 64;
   localparam int LW = 16;
   localparam int W8 = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic          start = 1'b0;
   logic [LW-1:0] len = '0;
   logic          addsub = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  out_data;
   logic          ovf;
   logic          busy;

   logic          start8 = 1'b0;
   logic [LW-1:0] len8 = '0;
   logic          addsub8 = 1'b0;
   logic          in_valid8 = 1'b0;
   logic          in_ready8;
   logic [W8-1:0] in_data8 = '0;
   logic          out_valid8;
   logic          out_ready8 = 1'b0;
   logic [W8-1:0] out_data8;
   logic          ovf8;
   logic          busy8;

   int errors = 0;
   int checks = 0;

   logic signed [W-1:0]  elems  [64];
   logic signed [W8-1:0] elems8 [16];

   vec_accum #(.WIDTH(W), .LEN_W(LW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .len       (len),
      .addsub    (addsub),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .ovf       (ovf),
      .busy      (busy)
   );

   vec_accum #(.WIDTH(W8), .LEN_W(LW)) dut8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start8),
      .len       (len8),
      .addsub    (addsub8),
      .in_valid  (in_valid8),
      .in_ready  (in_ready8),
      .in_data   (in_data8),
      .out_valid (out_valid8),
      .out_ready (out_ready8),
      .out_data  (out_data8),
      .ovf       (ovf8),
      .busy      (busy8)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Reference step: exact signed math, then wrap or clamp to w bits.
   function automatic void model_step(input int w, input bit sub,
                                      input logic signed [127:0] x,
                                      inout logic signed [127:0] a,
                                      inout bit of);
      logic signed [127:0] e;
      logic signed [127:0] maxv;
      logic signed [127:0] minv;
      maxv = (128'sd1 <<< (w - 1)) - 128'sd1;
      minv = -(128'sd1 <<< (w - 1));
      e = sub ? (a - x) : (a + x);
      if (e > maxv || e < minv) begin
         of = 1'b1;
`ifdef VEC_ACCUM_SAT_EN
         a = (e > maxv) ? maxv : minv;
`else
         a = (e <<< (128 - w)) >>> (128 - w);
`endif
      end else begin
         a = e;
      end
   endfunction

   // One complete run on the 64-bit instance using elems[0..n-1].
   task automatic do_run(input int n, input bit sub, input int gmin, input int gmax,
                         input int stall, input bit poke_start, input string tag);
      logic signed [127:0] ea;
      logic [W-1:0] exp_data;
      bit eo;
      int gap;
      ea = 0;
      eo = 1'b0;
      for (int i = 0; i < n; i++) begin
         model_step(W, sub, elems[i], ea, eo);
      end
      exp_data = ea[W-1:0];

      @(posedge clk); #1;
      start = 1'b1; len = LW'(n); addsub = sub;
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL %s busy after start: got %b expected 1", tag, busy);
      end

      for (int i = 0; i < n; i++) begin
         gap = $urandom_range(gmax, gmin);
         in_valid = 1'b0;
         for (int g = 0; g < gap; g++) begin
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
               errors++;
               $display("[TB] FAIL %s idle gap: got in_ready=%b out_valid=%b expected 1/0",
                        tag, in_ready, out_valid);
            end
            @(posedge clk); #1;
         end
         in_valid = 1'b1;
         in_data  = elems[i];
         checks++;
         if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s in_ready beat %0d: got %b expected 1", tag, i, in_ready);
         end
         @(posedge clk); #1;
         in_valid = 1'b0;
         in_data  = {$urandom(), $urandom()};
         if (i < n - 1) begin
            checks++;
            if (out_valid !== 1'b0) begin
               errors++;
               $display("[TB] FAIL %s early out_valid beat %0d: got %b expected 0", tag, i, out_valid);
            end
         end
      end

      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL %s out_valid latency: got %b expected 1", tag, out_valid);
      end
      checks++;
      if (out_data !== exp_data || ovf !== eo) begin
         errors++;
         $display("[TB] FAIL %s result: got data=%0d ovf=%b expected data=%0d ovf=%b",
                  tag, $signed(out_data), ovf, $signed(exp_data), eo);
      end

      out_ready = 1'b0;
      for (int s = 0; s < stall; s++) begin
         if (poke_start && s == 1) begin
            start = 1'b1; len = LW'(3); addsub = ~sub;
         end
         @(posedge clk); #1;
         start = 1'b0;
         checks++;
         if (out_valid !== 1'b1 || out_data !== exp_data || ovf !== eo || in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s stall %0d: got v=%b data=%0d ovf=%b in_ready=%b expected v=1 data=%0d ovf=%b in_ready=0",
                     tag, s, out_valid, $signed(out_data), ovf, in_ready, $signed(exp_data), eo);
         end
      end

      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL %s after handshake: got v=%b busy=%b in_ready=%b expected 0/0/0",
                  tag, out_valid, busy, in_ready);
      end
   endtask

   // One back-to-back run on the 8-bit instance using elems8[0..n-1].
   task automatic run8(input int n, input bit sub, input string tag);
      logic signed [127:0] ea;
      logic [W8-1:0] exp_data;
      bit eo;
      ea = 0;
      eo = 1'b0;
      for (int i = 0; i < n; i++) begin
         model_step(W8, sub, elems8[i], ea, eo);
      end
      exp_data = ea[W8-1:0];

      @(posedge clk); #1;
      start8 = 1'b1; len8 = LW'(n); addsub8 = sub;
      @(posedge clk); #1;
      start8 = 1'b0;
      for (int i = 0; i < n; i++) begin
         in_valid8 = 1'b1;
         in_data8  = elems8[i];
         @(posedge clk); #1;
      end
      in_valid8 = 1'b0;
      checks++;
      if (out_valid8 !== 1'b1 || out_data8 !== exp_data || ovf8 !== eo) begin
         errors++;
         $display("[TB] FAIL %s: got v=%b data=%0d ovf=%b expected v=1 data=%0d ovf=%b",
                  tag, out_valid8, $signed(out_data8), ovf8, $signed(exp_data), eo);
      end
      out_ready8 = 1'b1;
      @(posedge clk); #1;
      out_ready8 = 1'b0;
      checks++;
      if (busy8 !== 1'b0 || out_valid8 !== 1'b0) begin
         errors++;
         $display("[TB] FAIL %s release: got busy=%b v=%b expected 0/0", tag, busy8, out_valid8);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 || ovf !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset state: got in_ready=%b v=%b data=%0d ovf=%b busy=%b expected all 0",
                  in_ready, out_valid, out_data, ovf, busy);
      end
      checks++;
      if (out_valid8 !== 1'b0 || out_data8 !== '0 || ovf8 !== 1'b0 || busy8 !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset state 8b: got v=%b data=%0d ovf=%b busy=%b expected all 0",
                  out_valid8, out_data8, ovf8, busy8);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_sum4();
      elems[0] = 1; elems[1] = 2; elems[2] = 3; elems[3] = 4;
      do_run(4, 1'b0, 0, 0, 0, 1'b0, "sum4");
   endtask

   task automatic test_gaps();
      elems[0] = 5; elems[1] = -2; elems[2] = 7;
      do_run(3, 1'b1, 2, 2, 0, 1'b0, "sub_gaps");
   endtask

   task automatic test_zero_len();
      do_run(0, 1'b0, 0, 0, 3, 1'b1, "len0");
   endtask

   task automatic test_stall();
      for (int i = 0; i < 6; i++) begin
         elems[i] = W'($signed($urandom_range(2000, 0)) - 1000);
      end
      do_run(6, 1'b0, 0, 1, 5, 1'b1, "stall");
   endtask

   task automatic test_reset_mid();
      @(posedge clk); #1;
      start = 1'b1; len = LW'(5); addsub = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      in_valid = 1'b1; in_data = 64'd11;
      @(posedge clk); #1;
      in_data = 64'd22;
      @(posedge clk); #1;
      in_valid = 1'b0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 || ovf !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL mid-run reset: got in_ready=%b v=%b data=%0d ovf=%b busy=%b expected all 0",
                  in_ready, out_valid, out_data, ovf, busy);
      end
      rst_n = 1'b1;
      elems[0] = 3; elems[1] = 4;
      do_run(2, 1'b0, 0, 0, 0, 1'b0, "after_reset");
   endtask

   task automatic test_random();
      int n;
      bit sub;
      for (int r = 0; r < 20; r++) begin
         n = $urandom_range(12, 1);
         sub = 1'($urandom_range(1, 0));
         for (int i = 0; i < n; i++) begin
            if ($urandom_range(3, 0) == 0) begin
               elems[i] = {$urandom(), $urandom()};
            end else begin
               elems[i] = W'($signed($urandom_range(200000, 0)) - 100000);
            end
         end
         do_run(n, sub, 0, 2, $urandom_range(3, 0), 1'b0, $sformatf("rand%0d", r));
      end
   endtask

   task automatic test_overflow8();
      int n;
      elems8[0] = 8'sd100; elems8[1] = 8'sd100;
      run8(2, 1'b0, "ovf8_100_100");
      elems8[0] = -8'sd100; elems8[1] = 8'sd100;
      run8(2, 1'b1, "ovf8_neg_sub");
      for (int r = 0; r < 20; r++) begin
         n = $urandom_range(8, 1);
         for (int i = 0; i < n; i++) begin
            elems8[i] = 8'($urandom());
         end
         run8(n, 1'($urandom_range(1, 0)), $sformatf("rand8_%0d", r));
      end
   endtask

   // Safety net: stop with a FAIL if the sequence ever stalls.
   initial begin
      #2000000;
      $display("[TB] FAIL timeout: simulation did not complete");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      test_reset();
      test_sum4();
      test_gaps();
      test_zero_len();
      test_stall();
      test_reset_mid();
      test_random();
      test_overflow8();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/vec_accum.md
# vec_accum

Streaming signed reduction stage that sits directly upstream of the non-linear ops datapath. It sums or differences a run of `len` WIDTH-bit elements through the existing `add` block and hands one result to the consumer over a valid/ready handshake. Typical uses are softmax denominators and layernorm mean and variance sums.

## Interface
Parameters:
- `WIDTH`, default 64: element and accumulator width, two's complement.
- `LEN_W`, default 16: width of the element-count field.

Ports:
- `clk`, input, 1: the single clock.
- `rst_n`, input, 1: reset, synchronous and active-low.
- `start`, input, 1: one-cycle pulse that begins a run. Sampled only in IDLE.
- `len`, input, LEN_W: element count, latched on `start`.
- `addsub`, input, 1: latched on `start`. 0 gives acc + x; 1 gives acc − x.
- `in_valid`, input, 1: element handshake, valid.
- `in_ready`, output, 1: element handshake, ready.
- `in_data`, input, WIDTH: element value, signed.
- `out_valid`, output, 1: result handshake, valid.
- `out_ready`, input, 1: result handshake, ready.
- `out_data`, output, WIDTH: accumulated result, signed.
- `ovf`, output, 1: at least one signed overflow occurred this run. Valid alongside `out_valid`.
- `busy`, output, 1: high whenever state ≠ IDLE.

## Operation
- States are IDLE, ACC and OUT.
- IDLE:
  - `start` with `len` ≠ 0 goes to ACC, sets acc = 0, cnt = `len`, ovf = 0, and latches `addsub`.
  - `start` with `len` = 0 goes straight to OUT with acc = 0 and ovf = 0.
- ACC:
  - `in_ready` = 1.
  - Each beat with `in_valid` & `in_ready` does acc ← add(acc, in_data, addsub) and cnt ← cnt − 1.
  - The beat that brings cnt from 1 to 0 moves the block to OUT.
  - With no `in_valid`, the state holds and nothing changes.
- OUT:
  - `out_valid` = 1, `out_data` = acc, `ovf` = sticky flag.
  - Once `out_valid` & `out_ready` completes, the block returns to IDLE.
  - `out_data` and `ovf` stay stable while `out_ready` is low.
- `start` outside IDLE is ignored. No queuing.
- Overflow detection:
  - For add, overflow occurs when the operand signs are equal and the result sign differs.
  - For subtract, overflow occurs when the operand signs differ and the result sign differs from acc.
  - Any overflow beat sets `ovf`, which stays set until the next `start`.
- Count: `len` is unsigned, so a run is at most 2^LEN_W − 1 elements.
- `in_ready` = 0 in IDLE and OUT. Upstream must hold data until `in_ready`.

## Timing
- Reset values:
  - state = IDLE, acc = 0, cnt = 0.
  - `in_ready` = 0, `out_valid` = 0, `out_data` = 0, `ovf` = 0, `busy` = 0.
- The cycle after `start` is the first cycle `in_ready` can be 1.
- Each element costs one cycle. There is no bubble between accepted beats.
- After the last accepted beat, `out_valid` rises on the next cycle. Latency is `len` accepted beats + 1 cycle.
- `len` = 0 gives `out_valid` the cycle after `start`.
- After the output handshake, IDLE is reached on the next cycle. The earliest next `start` is accepted in that IDLE cycle.
- Asserting `rst_n` low during ACC or OUT returns to reset values on the next edge. The partial sum is discarded.
- All outputs are registered except `in_ready` and `busy`, which decode state combinationally.

## Configuration
- The macro is `VEC_ACCUM_SAT_EN`.
- When defined:
  - On an overflow beat, acc clamps to the signed max (positive overflow) or the signed min (negative overflow).
  - `ovf` still sets.
  - Later beats continue from the clamped value.
- When undefined:
  - acc wraps modulo 2^WIDTH, which is the raw `add` output.
  - `ovf` still reports overflow.

## Structure
- Shared package `nl_ops_pkg` holds:
  - the state enum `vec_accum_state_t` (IDLE, ACC, OUT);
  - the helper constants `SMAX(WIDTH)` and `SMIN(WIDTH)`.
- One sub-module: the existing `add` block, instantiated once with the same WIDTH.
  - acc drives `add_i1`, `in_data` drives `add_i2`, the latched mode drives `addsub`.
- Overflow and saturation logic live in `vec_accum` around the adder output.

## Test plan
1. Reset, then `start`, `len`=4, `addsub`=0, elements 1,2,3,4 on back-to-back cycles → `out_valid` 1 cycle after the 4th beat, `out_data`=10, `ovf`=0.
2. `len`=3, `addsub`=1, elements 5,−2,7 with `in_valid` gaps of 2 cycles → `out_data`=−10, and cnt advances only on accepted beats.
3. WIDTH=8, `len`=2, elements 100,100 → wrap build gives `out_data`=−56 with `ovf`=1; `VEC_ACCUM_SAT_EN` build gives 127 with `ovf`=1.
4. `len`=0 → `out_valid` the cycle after `start`, `out_data`=0, `ovf`=0. A `start` pulse in OUT is ignored.
5. `out_ready` held low 5 cycles in OUT → `out_data` and `ovf` stable, `in_ready`=0, and the 2nd run starts only after the handshake.
6. `rst_n` low mid-ACC after 2 of 5 beats → all outputs at reset values next cycle. A new run with 3,4 gives 7.
